manhattan_ring_walker: RTL
==========================

# manhattan_ring_walker

Inverse of the Mini-SPU Manhattan distance unit: given a center (cx, cy) on the 16x16 grid and a distance r in the unit's split-nibble format, enumerates every in-grid point (px, py) with |px-cx|+|py-cy| = r. Points are emitted one per handshake on a valid/ready stream. A done pulse carries the point count. The block sits beside the distance unit in the SPU datapath and serves ring/neighbourhood queries.

## Interface

- Parameters: none. Widths are fixed: 4-bit coordinates, 8-bit distance split into high and low nibbles.
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- cx, cy  in  4 each  center coordinate, unsigned 0..15; captured on start
- dist_high, dist_low  in  4 each  r = {dist_high, dist_low}, unsigned 0..255; captured on start
- out_valid  out  1  px/py hold a valid ring point
- out_ready  in  1  consumer accepts the point when out_valid && out_ready
- px, py  out  4 each  ring point coordinate
- busy  out  1  high in WALK and DONE
- done  out  1  one-cycle pulse when enumeration is complete
- count  out  6  number of points emitted; valid while done is high, held until the next start

## Operation

- States:
  - IDLE: waits for start.
  - WALK: enumerates candidates.
  - DONE: lasts one cycle, then returns to IDLE.
- On start in IDLE:
  - Capture cx, cy and r.
  - If r > 30, go to DONE with count = 0.
  - Otherwise go to WALK with dx = lo, phase = 0, count = 0.
  - lo = max(-r, -cx); hi = min(r, 15-cx). These are signed 7-bit values; lo ≤ 0 ≤ hi always holds.
- Candidate per cycle in WALK:
  - m = r - |dx|.
  - phase 0 gives dy = -m; phase 1 gives dy = +m.
  - x = cx + dx; y = cy + dy, computed at 7-bit signed width.
  - x is in range by construction. The candidate is valid iff 0 ≤ y ≤ 15.
- Output:
  - out_valid = WALK && candidate valid.
  - px = x[3:0], py = y[3:0]. px/py are combinational from registered state, so they are stable while out_valid && !out_ready.
- Advance when the candidate is invalid (skipped, costing one cycle) or a handshake occurs:
  - If phase 0 and m ≠ 0, set phase = 1.
  - Otherwise set phase = 0 and dx = dx + 1.
  - The point with m = 0 is emitted once, never twice.
- Termination: advancing past dx = hi moves the block to DONE.
- count increments on each handshake.
- Emission order: dx ascending; within one dx, the negative dy comes first.
- start is ignored while busy. out_ready is ignored outside WALK.
- Reset (asynchronous, any state, including mid-walk):
  - State = IDLE; all registers cleared.
  - out_valid = 0, px = py = 0, busy = 0, done = 0, count = 0.
  - A partially drained ring is abandoned.

## Timing

- Cycle 0: start sampled at the edge. Cycle 1: first candidate presented (WALK).
- With out_ready held high, one candidate resolves per cycle: one point out, or one skip.
- Total WALK cycles = number of candidates = Σ over dx in [lo, hi] of (m = 0 ? 1 : 2).
- done is high in the cycle after the last candidate resolves. busy drops one cycle later.
- A new start is accepted in the first IDLE cycle after DONE.
- r > 30: done is high in cycle 1, count = 0, and out_valid is never asserted.
- Backpressure: out_ready low stalls the walk indefinitely with no loss or duplication.

## Structure

- Shared package mini_spu_pkg:
  - COORD_W = 4, DIST_MAX = 30.
  - State encoding for IDLE / WALK / DONE.
  - Signed offset width constant OFS_W = 7.
- Sub-module manhattan_bounds (combinational): takes cx and r and produces lo, hi and the r > DIST_MAX flag. It is used only at start capture.
- Everything else is one FSM plus datapath in manhattan_ring_walker.

## Test plan

- cx = 5, cy = 9, r = 0 -> single point (5,9) in cycle 1; done in cycle 2; count = 1.
- cx = 0, cy = 0, r = 1, out_ready high -> cycle 1 is a skip (y = -1, out_valid low); then (0,1), then (1,0); count = 2.
- cx = 7, cy = 7, r = 2 (dist_high = 0, dist_low = 2), ready high -> points (5,7), (6,6), (6,8), (7,5), (7,9), (8,6), (8,8), (9,7) on 8 consecutive cycles; done in cycle 9; count = 8.
- Same as the previous test with out_ready low for 3 cycles while (6,6) is presented -> px/py hold (6,6); the sequence resumes unchanged; count = 8.
- r = 31 (dist_high = 1, dist_low = 15) -> no out_valid; done in cycle 1; count = 0. Then cx = 0, cy = 0, r = 30 -> only (15,15); count = 1.
- rst_n low after the third point of the r = 2 walk -> all outputs 0 immediately, state IDLE. A fresh start then replays the full 8-point ring.

Source files
------------

// File: rtl/mini_spu_pkg.sv
// Shared Mini-SPU constants and types for the Manhattan distance datapath.
// Offsets are signed 7-bit so that -30..+30 and coordinate sums fit without overflow.
package mini_spu_pkg;

  localparam int COORD_W  = 4;
  localparam int DIST_W   = 8;
  localparam int DIST_MAX = 30;
  localparam int OFS_W    = 7;
  localparam int COUNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } walk_state_t;

  typedef logic signed [OFS_W-1:0] ofs_t;

endpackage

// File: rtl/manhattan_bounds.sv
// Start-time helper: clips the dx sweep of a Manhattan ring to the grid columns
// and flags distances too large to ever land inside the 16x16 grid.
module manhattan_bounds
  import mini_spu_pkg::*;
(
  input  logic [COORD_W-1:0] cx,
  input  logic [DIST_W-1:0]  r,
  output ofs_t               lo,
  output ofs_t               hi,
  output logic               too_far
);

  logic [OFS_W-1:0] r_ofs;
  logic [OFS_W-1:0] cx_ofs;
  logic [OFS_W-1:0] room;

  assign too_far = (r > DIST_W'(DIST_MAX));

  // Out-of-range distances never walk, so the truncated value here is harmless.
  assign r_ofs  = too_far ? '0 : {2'b00, r[4:0]};
  assign cx_ofs = {3'b000, cx};
  assign room   = 7'd15 - cx_ofs;

  assign lo = (r_ofs < cx_ofs) ? ofs_t'(-r_ofs) : ofs_t'(-cx_ofs);
  assign hi = (r_ofs < room)   ? ofs_t'(r_ofs)  : ofs_t'(room);

endmodule

// File: rtl/manhattan_ring_walker.sv
// Enumerates every in-grid point at Manhattan distance r from (cx, cy),
// one point per valid/ready handshake, then pulses done with the point count.
module manhattan_ring_walker
  import mini_spu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [3:0]         dist_high,
  input  logic [3:0]         dist_low,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count
);

  walk_state_t        state;
  logic [COORD_W-1:0] cx_q;
  logic [COORD_W-1:0] cy_q;
  ofs_t               r_q;
  ofs_t               dx;
  ofs_t               hi_q;
  logic               phase;

  ofs_t lo_w;
  ofs_t hi_w;
  logic too_far;

  ofs_t abs_dx;
  ofs_t m;
  ofs_t dy;
  ofs_t y;
  logic cand_valid;
  logic handshake;
  logic advance;

  manhattan_bounds u_bounds (
    .cx      (cx),
    .r       ({dist_high, dist_low}),
    .lo      (lo_w),
    .hi      (hi_w),
    .too_far (too_far)
  );

  // Current candidate: x stays in the grid by the lo/hi clipping, only y needs a test.
  always_comb begin
    abs_dx     = dx[OFS_W-1] ? ofs_t'(-dx) : dx;
    m          = r_q - abs_dx;
    dy         = phase ? m : ofs_t'(-m);
    y          = ofs_t'({3'b000, cy_q}) + dy;
    cand_valid = (y[OFS_W-1:COORD_W] == '0);
  end

  assign out_valid = (state == ST_WALK) && cand_valid;
  assign handshake = out_valid && out_ready;
  assign advance   = (state == ST_WALK) && (!cand_valid || out_ready);
  assign px        = cx_q + dx[COORD_W-1:0];
  assign py        = y[COORD_W-1:0];
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cx_q  <= '0;
      cy_q  <= '0;
      r_q   <= '0;
      dx    <= '0;
      hi_q  <= '0;
      phase <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cx_q  <= cx;
            cy_q  <= cy;
            phase <= 1'b0;
            count <= '0;
            if (too_far) begin
              r_q   <= '0;
              dx    <= '0;
              hi_q  <= '0;
              state <= ST_DONE;
            end else begin
              r_q   <= ofs_t'({2'b00, dist_high[0], dist_low});
              dx    <= lo_w;
              hi_q  <= hi_w;
              state <= ST_WALK;
            end
          end
        end
        ST_WALK: begin
          if (handshake) begin
            count <= count + COUNT_W'(1);
          end
          // The m == 0 column has a single point, so it skips the second phase.
          if (advance) begin
            if (!phase && (m != '0)) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              dx    <= dx + ofs_t'(1);
              if (dx == hi_q) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
